// File: rtl/scoreboard_hdu.sv
// Issue-stage scoreboard: tracks in-flight register writes, decides stalls and forwarding sources.
// Define SCOREBOARD_FWD_EN to enable forwarding; otherwise consumers wait for the producer to retire.
module scoreboard_hdu #(
   parameter int AW       = 5,
   parameter int NUM_SRC  = 2,
   parameter int DEPTH    = 3,
   parameter int ALU_LAT  = 0,
   parameter int LOAD_LAT = 1,
   localparam int SW      = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  hold_i,
   input  logic                  flush_i,
   input  logic                  issue_valid_i,
   input  logic                  issue_we_i,
   input  logic                  issue_load_i,
   input  logic [AW-1:0]         issue_rd_i,
   input  logic [NUM_SRC*AW-1:0] src_addr_i,
   input  logic [NUM_SRC-1:0]    src_used_i,
   output logic                  stall_o,
   output logic [NUM_SRC*SW-1:0] fwd_sel_o,
   output logic [15:0]           stall_cnt_o
);

   localparam int MAX_LAT = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
   localparam int RW      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

   logic [DEPTH-1:0]   slot_valid;
   logic [AW-1:0]      slot_rd  [DEPTH];
   logic [RW-1:0]      slot_rem [DEPTH];

   logic [NUM_SRC-1:0] src_hit;
   logic [NUM_SRC-1:0] src_hazard;
   logic               accept;
`ifdef SCOREBOARD_FWD_EN
   logic [SW-1:0]      src_idx [NUM_SRC];
   logic [RW-1:0]      src_rem [NUM_SRC];
`endif

   // Scan oldest to youngest so the youngest matching slot overwrites older ones.
   always_comb begin
      src_hit    = '0;
      src_hazard = '0;
      fwd_sel_o  = '0;
      for (int n = 0; n < NUM_SRC; n++) begin
`ifdef SCOREBOARD_FWD_EN
         src_idx[n] = '0;
         src_rem[n] = '0;
`endif
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (src_used_i[n] && (src_addr_i[n*AW +: AW] != '0) &&
                slot_valid[k] && (slot_rd[k] == src_addr_i[n*AW +: AW])) begin
               src_hit[n] = 1'b1;
`ifdef SCOREBOARD_FWD_EN
               src_idx[n] = SW'(k);
               src_rem[n] = slot_rem[k];
`endif
            end
         end
`ifdef SCOREBOARD_FWD_EN
         src_hazard[n] = src_hit[n] && (src_rem[n] != '0);
         if (src_hit[n] && (src_rem[n] == '0))
            fwd_sel_o[n*SW +: SW] = src_idx[n] + SW'(1);
`else
         src_hazard[n] = src_hit[n];
`endif
      end
   end

   assign stall_o = issue_valid_i & (|src_hazard);
   assign accept  = issue_valid_i & ~stall_o & ~hold_i & ~flush_i;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         slot_valid  <= '0;
         stall_cnt_o <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            slot_rd[k]  <= '0;
            slot_rem[k] <= '0;
         end
      end else if (hold_i) begin
         if (flush_i)
            slot_valid[0] <= 1'b0;
      end else begin
         for (int k = DEPTH - 1; k > 0; k--) begin
            slot_valid[k] <= slot_valid[k-1];
            slot_rd[k]    <= slot_rd[k-1];
            slot_rem[k]   <= (slot_rem[k-1] != '0) ? slot_rem[k-1] - RW'(1) : '0;
         end
         slot_valid[0] <= accept & issue_we_i & (issue_rd_i != '0);
         slot_rd[0]    <= issue_rd_i;
         slot_rem[0]   <= issue_load_i ? RW'(LOAD_LAT) : RW'(ALU_LAT);
         // A flush also squashes the instruction that was in slot 0 as it moves on.
         if (flush_i)
            slot_valid[(DEPTH > 1) ? 1 : 0] <= 1'b0;
         if (stall_o && !flush_i && (stall_cnt_o != 16'hFFFF))
            stall_cnt_o <= stall_cnt_o + 16'd1;
      end
   end

endmodule
